timing_seq: RTL and testbench

Machine-cycle sequencer that drives the one-hot beat ring of the CPU control unit. It starts, stops, single-steps and halts phase generation, and groups beats into machine cycles (one FETCH cycle plus a variable number of EXEC cycles per instruction). It sits between the front-panel/run controls and the microinstruction decode logic, and replaces a free-running phase ring with a gated one.

---
 rtl/timing_seq.sv | 123 ++++++++++++
 tb/tb_timing_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_seq.sv
// Machine-cycle sequencer: gated one-hot beat ring grouped into FETCH/EXEC machine cycles.
// Optional memory wait states on the last beat are enabled by defining TIMING_SEQ_WAIT_EN.
module timing_seq #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             resume,
  input  logic [LEN_W-1:0] exec_len,
`ifdef TIMING_SEQ_WAIT_EN
  input  logic             ready,
`endif
  output logic [WIDTH-1:0] T,
  output logic             fetch,
  output logic             exec,
  output logic             busy,
  output logic             instr_done,
  output logic             halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [WIDTH-1:0] FIRST_BEAT = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [WIDTH-1:0] beat, beat_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             halt_flag, halt_flag_n;
  logic             mem_ok;
  logic             in_cycle;
  logic             cycle_end;
  logic             instr_end;
  logic             halt_now;

`ifdef TIMING_SEQ_WAIT_EN
  assign mem_ok = ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign in_cycle  = (state == FETCH) || (state == EXEC);
  assign cycle_end = in_cycle && beat[WIDTH-1] && mem_ok;
  // A FETCH with exec_len of zero is the whole instruction; EXEC ends when the last count expires.
  assign instr_end = cycle_end &&
                     (((state == FETCH) && (exec_len == '0)) ||
                      ((state == EXEC) && (cnt == LEN_W'(1))));
  // halt_req on the end clock itself still takes effect.
  assign halt_now  = halt_flag || halt_req;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      beat      <= '0;
      cnt       <= '0;
      halt_flag <= 1'b0;
    end else begin
      state     <= state_n;
      beat      <= beat_n;
      cnt       <= cnt_n;
      halt_flag <= halt_flag_n;
    end
  end

  always_comb begin
    state_n     = state;
    beat_n      = beat;
    cnt_n       = cnt;
    halt_flag_n = halt_flag;
    case (state)
      IDLE: begin
        if (run || step) begin
          state_n = FETCH;
          beat_n  = FIRST_BEAT;
        end
      end
      FETCH, EXEC: begin
        if (halt_req) halt_flag_n = 1'b1;
        if (!beat[WIDTH-1]) begin
          beat_n = beat << 1;
        end else if (cycle_end) begin
          beat_n = FIRST_BEAT;
          if (state == FETCH) begin
            cnt_n = exec_len;
            if (exec_len != '0) state_n = EXEC;
          end else begin
            cnt_n = cnt - LEN_W'(1);
          end
          if (instr_end) begin
            if (halt_now) begin
              state_n     = HALT;
              beat_n      = '0;
              halt_flag_n = 1'b0;
            end else if (run) begin
              state_n = FETCH;
            end else begin
              state_n = IDLE;
              beat_n  = '0;
            end
          end
        end
      end
      HALT: begin
        if (resume) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        beat_n  = '0;
      end
    endcase
  end

  assign T          = beat;
  assign fetch      = (state == FETCH);
  assign exec       = (state == EXEC);
  assign busy       = in_cycle;
  assign instr_done = instr_end;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_timing_seq.sv
// Directed bench for timing_seq (WIDTH=4): observes {T,fetch,exec,busy,instr_done,halted} each clock.
module tb_timing_seq;

  logic       clk;
  logic       clr;
  logic       run;
  logic       step;
  logic       halt_req;
  logic       resume;
  logic [2:0] exec_len;
`ifdef TIMING_SEQ_WAIT_EN
  logic       ready;
`endif
  logic [3:0] t;
  logic       fetch;
  logic       exec;
  logic       busy;
  logic       instr_done;
  logic       halted;
  logic [8:0] obs;

  int checks;
  int errors;

  timing_seq #(.WIDTH(4), .LEN_W(3)) dut (
    .clk(clk),
    .clr(clr),
    .run(run),
    .step(step),
    .halt_req(halt_req),
    .resume(resume),
    .exec_len(exec_len),
`ifdef TIMING_SEQ_WAIT_EN
    .ready(ready),
`endif
    .T(t),
    .fetch(fetch),
    .exec(exec),
    .busy(busy),
    .instr_done(instr_done),
    .halted(halted)
  );

  assign obs = {t, fetch, exec, busy, instr_done, halted};

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    clr = 1'b1;
    tick();
    tick();
    exp = 9'b0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_held obs=%b exp=%b", obs, exp);
    end
    clr = 1'b0;
    tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_idle obs=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_continuous();
    logic [8:0] exp;
    logic [3:0] et;
    exec_len = 3'd0;
    run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      et = 4'b0001 << ((k - 1) % 4);
      exp = {et, 1'b1, 1'b0, 1'b1, (k % 4 == 0), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL continuous k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    run = 1'b0;
    tick();
    exp = 9'b0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL continuous_stop obs=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_multi_cycle();
    logic [8:0] exp;
    logic [3:0] et;
    logic f, e, d;
    exec_len = 3'd2;
    run = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      et = (k == 17) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
      f = (k <= 4) || (k >= 13 && k <= 16);
      e = (k >= 5) && (k <= 12);
      d = (k == 12) || (k == 16);
      exp = {et, f, e, f | e, d, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL multi_cycle k=%0d obs=%b exp=%b", k, obs, exp);
      end
      if (k == 13) begin
        run = 1'b0;
        exec_len = 3'd0;
      end
    end
  endtask

  task automatic test_step();
    logic [8:0] exp;
    logic [3:0] et;
    logic f, e, d;
    run = 1'b0;
    exec_len = 3'd1;
    step = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1 || k == 3) step = 1'b0;
      et = (k <= 8) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
      f = (k <= 4);
      e = (k >= 5) && (k <= 8);
      d = (k == 8);
      exp = {et, f, e, f | e, d, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL step k=%0d obs=%b exp=%b", k, obs, exp);
      end
      if (k == 2) step = 1'b1;
    end
  endtask

  task automatic test_halt_resume();
    logic [8:0] exp;
    logic [3:0] et;
    logic f, e, d;
    run = 1'b1;
    exec_len = 3'd1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 7) halt_req = 1'b0;
      et = (k <= 8) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
      f = (k <= 4);
      e = (k >= 5) && (k <= 8);
      d = (k == 8);
      exp = {et, f, e, f | e, d, (k >= 9)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt k=%0d obs=%b exp=%b", k, obs, exp);
      end
      if (k == 6) halt_req = 1'b1;
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    exp = 9'b0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL resume_idle obs=%b exp=%b", obs, exp);
    end
    tick();
    exp = {4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL resume_fetch obs=%b exp=%b", obs, exp);
    end
    run = 1'b0;
    exec_len = 3'd0;
    for (int j = 2; j <= 5; j++) begin
      tick();
      et = (j <= 4) ? (4'b0001 << (j - 1)) : 4'b0000;
      f = (j <= 4);
      exp = {et, f, 1'b0, f, (j == 4), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt_drain j=%0d obs=%b exp=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_halt_on_end();
    logic [8:0] exp;
    logic [3:0] et;
    run = 1'b1;
    exec_len = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      et = 4'b0001 << (k - 1);
      exp = {et, 1'b1, 1'b0, 1'b1, (k == 4), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt_end k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    exp = 9'b000000001;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL halt_end_enter obs=%b exp=%b", obs, exp);
    end
    run = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    exp = 9'b0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL halt_end_resume obs=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    logic [3:0] et;
    logic f, e, d;
    run = 1'b1;
    exec_len = 3'd1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 7) halt_req = 1'b0;
      et = 4'b0001 << ((k - 1) % 4);
      f = (k <= 4);
      e = (k >= 5);
      exp = {et, f, e, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre k=%0d obs=%b exp=%b", k, obs, exp);
      end
      if (k == 6) halt_req = 1'b1;
    end
    clr = 1'b1;
    tick();
    exp = 9'b0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_mid_clear obs=%b exp=%b", obs, exp);
    end
    clr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      et = 4'b0001 << ((k - 1) % 4);
      f = (k <= 4) || (k == 9);
      e = (k >= 5) && (k <= 8);
      d = (k == 8);
      exp = {et, f, e, 1'b1, d, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_restart k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    run = 1'b0;
    exec_len = 3'd0;
    for (int j = 2; j <= 5; j++) begin
      tick();
      et = (j <= 4) ? (4'b0001 << (j - 1)) : 4'b0000;
      f = (j <= 4);
      exp = {et, f, 1'b0, f, (j == 4), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_drain j=%0d obs=%b exp=%b", j, obs, exp);
      end
    end
  endtask

`ifdef TIMING_SEQ_WAIT_EN
  task automatic test_wait_states();
    logic [8:0] exp;
    logic [3:0] et;
    logic f, e, d;
    run = 1'b1;
    exec_len = 3'd0;
    ready = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k >= 14) run = 1'b0;
      if (k >= 14) exec_len = 3'd0;
      if (k <= 4)       et = 4'b0001 << (k - 1);
      else if (k <= 7)  et = 4'b1000;
      else if (k <= 10) et = 4'b0001 << (k - 8);
      else if (k <= 13) et = 4'b1000;
      else if (k <= 21) et = 4'b0001 << ((k - 14) % 4);
      else              et = 4'b0000;
      f = (k <= 13);
      e = (k >= 14) && (k <= 21);
      d = (k == 7) || (k == 21);
      exp = {et, f, e, f | e, d, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wait k=%0d obs=%b exp=%b", k, obs, exp);
      end
      if (k == 3 || k == 10) ready = 1'b0;
      if (k == 6) ready = 1'b1;
      if (k == 12) begin
        exec_len = 3'd2;
        ready = 1'b1;
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1;
    run = 1'b0;
    step = 1'b0;
    halt_req = 1'b0;
    resume = 1'b0;
    exec_len = 3'd0;
`ifdef TIMING_SEQ_WAIT_EN
    ready = 1'b1;
`endif
    test_reset();
    test_continuous();
    test_multi_cycle();
    test_step();
    test_halt_resume();
    test_halt_on_end();
    test_reset_mid();
`ifdef TIMING_SEQ_WAIT_EN
    test_wait_states();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
